receive: RTL and testbench
==========================

// Module: receive
// PURPOSE
//  UART serial receiver, the far end of the mini-computer UART transmitter.
//  Deserialises frames: start(0), 8 data LSB-first, parity, stop(1).
//  Parity bit = XOR(data) ^ PRT.
//  Presents the byte in RDR with RDRF/PE/FE/OE status for the bus-side
//  register file, cleared by a CPU read strobe.
// PARAMETERS
//  OVS          16  RxEn ticks per bit period (even, 8..32)
//  SYNC_STAGES  2   flops in the RxD metastability synchroniser (>=2)
// PORTS
//  clk      in   1  system clock, all state on rising edge
//  rst_n    in   1  asynchronous reset, active-low
//  RxEn     in   1  one-clk sample tick at OVS x baud, from the baud generator
//  RxD      in   1  serial line, asynchronous, idle high
//  PRT      in   1  parity select, XORed into the expected parity
//  rd_rdr   in   1  CPU read strobe; clears RDRF/PE/FE/OE
//  RDR      out  8  received data register
//  RDRF     out  1  receive data register full
//  PE       out  1  parity error on the byte in RDR
//  FE       out  1  framing error (stop bit sampled 0)
//  OE       out  1  overrun: frame completed while RDRF=1
//  setRC    out  1  one-clk pulse per completed frame, error or not
// BEHAVIOUR
//  Reset: RDR=8'hFF, RDRF=PE=FE=OE=setRC=0, state IDLE, counters 0, sync flops 1.
//  Reset mid-frame: the partial frame is discarded.
//  Sample counter SmpCnt (log2 OVS bits) advances only on RxEn.
//  Bit counter BitCnt (0..7).
//  FSM (uart_pkg::rx_st_t):
//   IDLE   - on RxEn with rxs=0: SmpCnt<=0, go START.
//   START  - on RxEn at SmpCnt==OVS/2-1: rxs=1 -> IDLE (glitch);
//            else SmpCnt<=0, BitCnt<=0, go DATA.
//   DATA   - on RxEn at SmpCnt==OVS-1: shift sample into RSR[7]
//            (right shift, LSB first).
//            BitCnt==7 -> PARITY, else BitCnt+1.
//   PARITY - at SmpCnt==OVS-1: latch rx_par, go STOP.
//   STOP   - at SmpCnt==OVS-1 (mid stop bit): commit, go IDLE;
//            if sample=0 go BREAK instead.
//   BREAK  - wait for rxs=1 on RxEn, then IDLE. Prevents re-triggering on a held-low line.
//  Commit (the clk after the stop-bit sample):
//   - RDR<=RSR; RDRF<=1; setRC pulses 1 clk.
//   - PE<=(rx_par != ^RSR ^ PRT); FE<=~stop.
//   - OE<=1 if RDRF=1 and rd_rdr=0; RDR is overwritten with the new byte.
//  rd_rdr alone clears RDRF, PE, FE, OE next clk. RDR holds its value.
//  rd_rdr and commit in the same clk: commit wins. RDRF=1, new PE/FE, OE=0.
//  Latency: SYNC_STAGES clk from the line edge to rxs.
//   RDRF rises 1 clk after the mid-stop-bit RxEn.
//  Without RxEn pulses the FSM is frozen. Counters wrap only via explicit reset to 0.
// CONFIGURATION
//  UART_RX_MAJORITY_EN defined:
//   - each bit value = 2-of-3 majority of rxs at SmpCnt OVS/2-2, OVS/2-1, OVS/2.
//   - the data/parity/stop decision moves to SmpCnt==OVS/2 and the counter wraps at OVS-1.
//   - START glitch check uses the majority too.
//   - adds a 3-bit sample shift register.
//  Not defined: single sample of rxs at SmpCnt OVS/2-1 (start) and OVS-1 (data/parity/stop).
//  Frame alignment is identical in both builds.
// STRUCTURE
//  uart_pkg: rx_st_t enum (IDLE,START,DATA,PARITY,STOP,BREAK), DATA_W=8,
//   IDLE_LVL=1'b1, parity helper function, shared with the transmitter.
//  Sub-module uart_sync: SYNC_STAGES flop chain, reset to 1, RxD -> rxs.
//  Everything else lives in receive.
// TESTING
//  (OVS=16, RxEn every 4 clk, PRT=0 unless stated)
//  1 Send 0xA5, parity 0, stop 1 -> RDR=8'hA5, RDRF=1, PE=FE=OE=0, one setRC pulse.
//  2 Send 0x3C, parity 1 -> RDR=8'h3C, PE=1. Repeat with PRT=1, parity 1 -> PE=0.
//  3 Send 0x81, stop 0, line held low 3 bit times -> FE=1.
//     No second frame until the line returns high.
//  4 RxD low for 5 RxEn ticks, then high -> back to IDLE, RDRF=0, no setRC.
//  5 Two frames 0x11 then 0x22, no rd_rdr -> RDR=8'h22, OE=1.
//     rd_rdr -> RDRF=OE=0, RDR=8'h22.
//  6 rst_n low mid-data of 0x55 -> all outputs at reset values.
//     Next frame 0x0F is received cleanly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the mini-computer UART transmitter and
// receiver. Provides the receiver state enumeration, the data width, the
// line idle level and the parity helper.
package uart_pkg;

    localparam int unsigned DATA_W   = 8;
    localparam logic        IDLE_LVL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_st_t;

    // Parity bit carried on the line: XOR of the data bits, XORed with PRT.
    function automatic logic parity_bit(input logic [DATA_W-1:0] d,
                                        input logic              prt);
        return (^d) ^ prt;
    endfunction

endpackage

// File: rtl/receive_if.sv
// receive_if: serial line, sample tick and bus-side register signals of the
// UART receiver.
//   RxEn   : one-clk sample tick at OVS x baud
//   RxD    : asynchronous serial line, idle high
//   PRT    : parity select
//   rd_rdr : CPU read strobe, clears the status flags
//   RDR    : received data register
//   RDRF   : data register full
//   PE/FE/OE : parity / framing / overrun error
//   setRC  : one-clk pulse per completed frame
// Modports: master = line/bus side (drives RxEn, RxD, PRT, rd_rdr),
//           slave  = receiver.
interface receive_if;
    import uart_pkg::*;

    logic              RxEn;
    logic              RxD;
    logic              PRT;
    logic              rd_rdr;
    logic [DATA_W-1:0] RDR;
    logic              RDRF;
    logic              PE;
    logic              FE;
    logic              OE;
    logic              setRC;

    modport master (
        output RxEn, RxD, PRT, rd_rdr,
        input  RDR, RDRF, PE, FE, OE, setRC
    );

    modport slave (
        input  RxEn, RxD, PRT, rd_rdr,
        output RDR, RDRF, PE, FE, OE, setRC
    );

endinterface

// File: rtl/uart_sync.sv
// uart_sync: metastability synchroniser for the asynchronous RxD line.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous reset, active-low (chain resets to the idle level)
//   d_i   : asynchronous input
//   q_o   : synchronised output, STAGES clk after d_i
module uart_sync
    import uart_pkg::*;
#(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= {STAGES{IDLE_LVL}};
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/receive.sv
// receive: UART serial receiver. Frame: start(0), 8 data bits LSB first,
// parity (XOR(data) ^ PRT), stop(1). The received byte is presented in RDR
// with RDRF/PE/FE/OE status, cleared by rd_rdr.
// Ports:
//   clk   : system clock, all state on the rising edge
//   rst_n : asynchronous reset, active-low
//   bus   : receive_if.slave (RxEn, RxD, PRT, rd_rdr in; RDR, RDRF, PE,
//           FE, OE, setRC out)
// Parameters: OVS (RxEn ticks per bit, even, 8..32), SYNC_STAGES (>=2).
// Build option UART_RX_MAJORITY_EN: each bit is the 2-of-3 majority of the
// samples at SmpCnt OVS/2-2, OVS/2-1, OVS/2, decided at SmpCnt==OVS/2.
// Otherwise a single sample is taken at OVS/2-1 (start) and OVS-1 (others).
module receive
    import uart_pkg::*;
#(
    parameter int unsigned OVS         = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    receive_if.slave  bus
);

    localparam int unsigned CW = $clog2(OVS);
    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t CNT_LAST = cnt_t'(OVS - 1);
`ifdef UART_RX_MAJORITY_EN
    localparam cnt_t START_DECIDE = cnt_t'(OVS / 2);
    localparam cnt_t BIT_DECIDE   = cnt_t'(OVS / 2);
`else
    localparam cnt_t START_DECIDE = cnt_t'(OVS / 2 - 1);
    localparam cnt_t BIT_DECIDE   = CNT_LAST;
`endif

    logic rxs;

    uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (bus.RxD),
        .q_o   (rxs)
    );

    rx_st_t            state_q, state_d;
    cnt_t              smp_q, smp_d;
    logic [2:0]        bit_q, bit_d;
    logic [DATA_W-1:0] rsr_q, rsr_d;
    logic              par_q, par_d;
    logic              stop_q, stop_d;
    logic              commit_q, commit_d;

    logic [DATA_W-1:0] rdr_q, rdr_d;
    logic              rdrf_q, rdrf_d;
    logic              pe_q, pe_d;
    logic              fe_q, fe_d;
    logic              oe_q, oe_d;
    logic              setrc_q, setrc_d;

    logic              sample;

`ifdef UART_RX_MAJORITY_EN
    // Two previous samples plus the current one form the 3-sample window.
    logic [1:0] hist_q, hist_d;
    logic [2:0] win;

    always_comb begin
        win    = {hist_q, rxs};
        sample = (win[0] & win[1]) | (win[0] & win[2]) | (win[1] & win[2]);
        hist_d = hist_q;
        if (bus.RxEn) begin
            hist_d = {hist_q[0], rxs};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= {2{IDLE_LVL}};
        end else begin
            hist_q <= hist_d;
        end
    end
`else
    assign sample = rxs;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            smp_q    <= '0;
            bit_q    <= '0;
            rsr_q    <= '0;
            par_q    <= 1'b0;
            stop_q   <= IDLE_LVL;
            commit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            smp_q    <= smp_d;
            bit_q    <= bit_d;
            rsr_q    <= rsr_d;
            par_q    <= par_d;
            stop_q   <= stop_d;
            commit_q <= commit_d;
        end
    end

    // Decision and wrap points coincide in the single-sample build; in the
    // majority build the bit is decided at OVS/2 and the state advances at
    // the wrap, so the frame alignment stays the same in both builds.
    always_comb begin
        state_d  = state_q;
        smp_d    = smp_q;
        bit_d    = bit_q;
        rsr_d    = rsr_q;
        par_d    = par_q;
        stop_d   = stop_q;
        commit_d = 1'b0;
        if (bus.RxEn) begin
            smp_d = smp_q + 1'b1;
            unique case (state_q)
                IDLE: begin
                    smp_d = '0;
                    if (!rxs) begin
                        state_d = START;
                    end
                end
                START: begin
                    if (smp_q == START_DECIDE && sample) begin
                        // Line back high at mid start bit: glitch.
                        smp_d   = '0;
                        state_d = IDLE;
                    end
`ifdef UART_RX_MAJORITY_EN
                    else if (smp_q == CNT_LAST) begin
`else
                    else if (smp_q == START_DECIDE) begin
`endif
                        smp_d   = '0;
                        bit_d   = '0;
                        state_d = DATA;
                    end
                end
                DATA: begin
                    if (smp_q == BIT_DECIDE) begin
                        rsr_d = {sample, rsr_q[DATA_W-1:1]};
                    end
                    if (smp_q == CNT_LAST) begin
                        smp_d = '0;
                        if (bit_q == 3'd7) begin
                            state_d = PARITY;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (smp_q == BIT_DECIDE) begin
                        par_d = sample;
                    end
                    if (smp_q == CNT_LAST) begin
                        smp_d   = '0;
                        state_d = STOP;
                    end
                end
                STOP: begin
                    if (smp_q == BIT_DECIDE) begin
                        commit_d = 1'b1;
                        stop_d   = sample;
                        smp_d    = '0;
                        state_d  = sample ? IDLE : BREAK;
                    end
                end
                BREAK: begin
                    smp_d = '0;
                    if (rxs) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    smp_d   = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdr_q   <= '1;
            rdrf_q  <= 1'b0;
            pe_q    <= 1'b0;
            fe_q    <= 1'b0;
            oe_q    <= 1'b0;
            setrc_q <= 1'b0;
        end else begin
            rdr_q   <= rdr_d;
            rdrf_q  <= rdrf_d;
            pe_q    <= pe_d;
            fe_q    <= fe_d;
            oe_q    <= oe_d;
            setrc_q <= setrc_d;
        end
    end

    // A commit takes priority over a simultaneous CPU read.
    always_comb begin
        rdr_d   = rdr_q;
        rdrf_d  = rdrf_q;
        pe_d    = pe_q;
        fe_d    = fe_q;
        oe_d    = oe_q;
        setrc_d = 1'b0;
        if (commit_q) begin
            rdr_d   = rsr_q;
            rdrf_d  = 1'b1;
            setrc_d = 1'b1;
            pe_d    = (par_q != parity_bit(rsr_q, bus.PRT));
            fe_d    = ~stop_q;
            oe_d    = rdrf_q & ~bus.rd_rdr;
        end else if (bus.rd_rdr) begin
            rdrf_d = 1'b0;
            pe_d   = 1'b0;
            fe_d   = 1'b0;
            oe_d   = 1'b0;
        end
    end

    assign bus.RDR   = rdr_q;
    assign bus.RDRF  = rdrf_q;
    assign bus.PE    = pe_q;
    assign bus.FE    = fe_q;
    assign bus.OE    = oe_q;
    assign bus.setRC = setrc_q;

endmodule

// File: tb/tb_receive.sv
// tb_receive: self-checking bench for the UART receiver (OVS=16, RxEn every
// 4 clk). A frame-level model tracks RDR/RDRF/PE/FE/OE and the number of
// setRC pulses from the frames the bench puts on the line.
module tb_receive;
    import uart_pkg::*;

    localparam int unsigned OVS      = 16;
    localparam int unsigned RXEN_DIV = 4;
    localparam int unsigned BIT_CLKS = OVS * RXEN_DIV;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    receive_if bus();

    receive #(.OVS(OVS), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    logic [7:0] m_rdr    = 8'hFF;
    logic       m_rdrf   = 1'b0;
    logic       m_pe     = 1'b0;
    logic       m_fe     = 1'b0;
    logic       m_oe     = 1'b0;
    int         m_pulses = 0;
    logic       cur_prt  = 1'b0;

    initial begin
        bus.RxEn = 1'b0;
        forever begin
            repeat (RXEN_DIV - 1) @(posedge clk);
            #1 bus.RxEn = 1'b1;
            @(posedge clk);
            #1 bus.RxEn = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (bus.setRC === 1'b1) pulses++;
    end

    function automatic logic [11:0] obs();
        return {bus.RDR, bus.RDRF, bus.PE, bus.FE, bus.OE};
    endfunction

    function automatic logic [11:0] model();
        return {m_rdr, m_rdrf, m_pe, m_fe, m_oe};
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        bus.RxD = v;
        wait_clks(BIT_CLKS);
    endtask

    task automatic model_commit(input logic [7:0] d, input logic par, input logic stop);
        m_oe  = m_rdrf;
        m_rdr = d;
        m_rdrf = 1'b1;
        m_pe  = (par != ((^d) ^ cur_prt));
        m_fe  = ~stop;
        m_pulses++;
    endtask

    // Leaves RxD at the stop level; the caller decides how the line idles.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(par);
        drive_bit(stop);
        model_commit(d, par, stop);
    endtask

    task automatic idle_line(input int clks);
        bus.RxD = 1'b1;
        wait_clks(clks);
    endtask

    task automatic read_rdr();
        bus.rd_rdr = 1'b1;
        wait_clks(1);
        bus.rd_rdr = 1'b0;
        wait_clks(1);
        m_rdrf = 1'b0;
        m_pe   = 1'b0;
        m_fe   = 1'b0;
        m_oe   = 1'b0;
    endtask

    task automatic test_reset();
        bus.RxD = 1'b1; bus.rd_rdr = 1'b0; bus.PRT = 1'b0;
        rst_n = 1'b0;
        wait_clks(3);
        checks++;
        if (obs() !== {8'hFF, 4'b0000}) begin
            errors++;
            $display("FAIL reset_status: got %h want %h", obs(), {8'hFF, 4'b0000});
        end
        checks++;
        if (bus.setRC !== 1'b0) begin
            errors++;
            $display("FAIL reset_setRC: got %b want 0", bus.setRC);
        end
        rst_n = 1'b1;
        idle_line(BIT_CLKS);
    endtask

    task automatic test_basic();
        send_frame(8'hA5, 1'b0, 1'b1);
        idle_line(BIT_CLKS);
        checks++;
        if (obs() !== model()) begin
            errors++;
            $display("FAIL basic_status: got %h want %h", obs(), model());
        end
        checks++;
        if (pulses !== m_pulses) begin
            errors++;
            $display("FAIL basic_setRC: got %0d pulses want %0d", pulses, m_pulses);
        end
        read_rdr();
        checks++;
        if (obs() !== model()) begin
            errors++;
            $display("FAIL basic_read: got %h want %h", obs(), model());
        end
    endtask

    task automatic test_parity();
        send_frame(8'h3C, 1'b1, 1'b1);
        idle_line(BIT_CLKS);
        checks++;
        if (obs() !== model() || bus.PE !== 1'b1) begin
            errors++;
            $display("FAIL parity_bad: got %h want %h", obs(), model());
        end
        read_rdr();
        cur_prt = 1'b1;
        bus.PRT = 1'b1;
        send_frame(8'h3C, 1'b1, 1'b1);
        idle_line(BIT_CLKS);
        checks++;
        if (obs() !== model() || bus.PE !== 1'b0) begin
            errors++;
            $display("FAIL parity_prt: got %h want %h", obs(), model());
        end
        read_rdr();
        cur_prt = 1'b0;
        bus.PRT = 1'b0;
    endtask

    task automatic test_framing();
        send_frame(8'h81, 1'b0, 1'b0);
        wait_clks(3 * BIT_CLKS);
        idle_line(2 * BIT_CLKS);
        checks++;
        if (obs() !== model() || bus.FE !== 1'b1) begin
            errors++;
            $display("FAIL framing_status: got %h want %h", obs(), model());
        end
        checks++;
        if (pulses !== m_pulses) begin
            errors++;
            $display("FAIL framing_setRC: got %0d pulses want %0d", pulses, m_pulses);
        end
        read_rdr();
    endtask

    task automatic test_glitch();
        bus.RxD = 1'b0;
        wait_clks(5 * RXEN_DIV);
        idle_line(2 * BIT_CLKS);
        checks++;
        if (obs() !== model() || bus.RDRF !== 1'b0) begin
            errors++;
            $display("FAIL glitch_status: got %h want %h", obs(), model());
        end
        checks++;
        if (pulses !== m_pulses) begin
            errors++;
            $display("FAIL glitch_setRC: got %0d pulses want %0d", pulses, m_pulses);
        end
    endtask

    task automatic test_overrun();
        send_frame(8'h11, 1'b0, 1'b1);
        idle_line(BIT_CLKS);
        send_frame(8'h22, 1'b0, 1'b1);
        idle_line(BIT_CLKS);
        checks++;
        if (obs() !== model() || bus.OE !== 1'b1) begin
            errors++;
            $display("FAIL overrun_status: got %h want %h", obs(), model());
        end
        read_rdr();
        checks++;
        if (obs() !== {8'h22, 4'b0000}) begin
            errors++;
            $display("FAIL overrun_read: got %h want %h", obs(), {8'h22, 4'b0000});
        end
    endtask

    // rd_rdr held high across the commit: the new byte must still land.
    task automatic test_commit_vs_read();
        logic [7:0] d;
        bit         seen;
        d = 8'h6E;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit((^d) ^ cur_prt);
        bus.RxD = 1'b1;
        bus.rd_rdr = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < int'(BIT_CLKS) && !seen; c++) begin
            wait_clks(1);
            if (bus.setRC === 1'b1) begin
                seen = 1'b1;
                bus.rd_rdr = 1'b0;
                checks++;
                if (obs() !== {d, 4'b1000}) begin
                    errors++;
                    $display("FAIL commit_vs_read: got %h want %h", obs(), {d, 4'b1000});
                end
            end
        end
        bus.rd_rdr = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL commit_vs_read_timeout: got no setRC within %0d clk", BIT_CLKS);
        end
        m_rdr = d; m_rdrf = 1'b1; m_pe = 1'b0; m_fe = 1'b0; m_oe = 1'b0;
        m_pulses++;
        idle_line(BIT_CLKS);
        read_rdr();
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d;
        d = 8'h55;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        rst_n = 1'b0;
        bus.RxD = 1'b1;
        wait_clks(2);
        checks++;
        if (obs() !== {8'hFF, 4'b0000} || bus.setRC !== 1'b0) begin
            errors++;
            $display("FAIL midframe_reset: got %h/%b want %h/0", obs(), bus.setRC, {8'hFF, 4'b0000});
        end
        m_rdr = 8'hFF; m_rdrf = 1'b0; m_pe = 1'b0; m_fe = 1'b0; m_oe = 1'b0;
        rst_n = 1'b1;
        idle_line(2 * BIT_CLKS);
        send_frame(8'h0F, 1'b0, 1'b1);
        idle_line(BIT_CLKS);
        checks++;
        if (obs() !== model()) begin
            errors++;
            $display("FAIL midframe_next: got %h want %h", obs(), model());
        end
        checks++;
        if (pulses !== m_pulses) begin
            errors++;
            $display("FAIL midframe_setRC: got %0d pulses want %0d", pulses, m_pulses);
        end
        read_rdr();
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic       par, stop;
        for (int n = 0; n < 20; n++) begin
            if ($urandom_range(0, 1) == 1) read_rdr();
            cur_prt = 1'($urandom_range(0, 1));
            bus.PRT = cur_prt;
            wait_clks($urandom_range(0, 7));
            d    = 8'($urandom);
            par  = ((^d) ^ cur_prt) ^ ($urandom_range(0, 3) == 0);
            stop = ($urandom_range(0, 4) != 0);
            send_frame(d, par, stop);
            if (!stop) wait_clks($urandom_range(0, BIT_CLKS));
            idle_line(BIT_CLKS);
            checks++;
            if (obs() !== model()) begin
                errors++;
                $display("FAIL random_status[%0d]: got %h want %h (d=%h par=%b stop=%b prt=%b)",
                         n, obs(), model(), d, par, stop, cur_prt);
            end
            checks++;
            if (pulses !== m_pulses) begin
                errors++;
                $display("FAIL random_setRC[%0d]: got %0d pulses want %0d", n, pulses, m_pulses);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_framing();
        test_glitch();
        test_overrun();
        test_commit_vs_read();
        test_reset_midframe();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
